// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one full-subtractor slice per clock, LSB first.
// Operands load in parallel on an accepted start; diff/bout are valid from done until the next start.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               brw_q, brw_d;
    logic               bout_q, bout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic accept;
    logic last;
    logic d_bit;
    logic b_bit;

    // start is only honoured when no operation is in flight
    assign accept = start && (state_q == StIdle || state_q == StDone);
    assign last   = (cnt_q == CNT_W'(WIDTH - 1));

    // Full-subtractor slice on the current LSBs
    assign d_bit = a_sr_q[0] ^ b_sr_q[0] ^ brw_q;
    assign b_bit = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & brw_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            diff_q  <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            diff_q  <= diff_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  state_d = start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        a_sr_d = a_sr_q;
        b_sr_d = b_sr_q;
        diff_d = diff_q;
        brw_d  = brw_q;
        bout_d = bout_q;
        cnt_d  = cnt_q;
        if (accept) begin
            a_sr_d = a_in;
            b_sr_d = b_in;
            diff_d = '0;
            brw_d  = bin;
            cnt_d  = '0;
        end else if (state_q == StRun) begin
            a_sr_d = a_sr_q >> 1;
            b_sr_d = b_sr_q >> 1;
            diff_d = {d_bit, diff_q[WIDTH-1:1]};
            brw_d  = b_bit;
            cnt_d  = cnt_q + CNT_W'(1);
            if (last) bout_d = b_bit;
        end
    end

    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StDone);
        diff = diff_q;
        bout = bout_q;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed, randomized and WIDTH=4 exhaustive checks
// against an arithmetic reference model.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       bin4 = 1'b0;
    logic       busy4, done4, bout4;
    logic [3:0] diff4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start8),
        .a_in (a8),
        .b_in (b8),
        .bin  (bin8),
        .busy (busy8),
        .done (done8),
        .diff (diff8),
        .bout (bout8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start4),
        .a_in (a4),
        .b_in (b4),
        .bin  (bin4),
        .busy (busy4),
        .done (done4),
        .diff (diff4),
        .bout (bout4)
    );

    // Reference: {bout,diff} = a - b - bin taken modulo 2^(W+1)
    function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic bi);
        return {1'b0, a} - {1'b0, b} - {8'b0, bi};
    endfunction

    function automatic logic [4:0] model4(input logic [3:0] a, input logic [3:0] b, input logic bi);
        return {1'b0, a} - {1'b0, b} - {4'b0, bi};
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi, input string name);
        logic [8:0] exp;
        int cyc;
        int busy_cnt;
        bit got;
        bit overlap;
        exp = model8(a, b, bi);
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        cyc = 0; busy_cnt = 0; got = 0; overlap = 0;
        while (!got && cyc < 20) begin
            if (busy8) busy_cnt++;
            if (busy8 && done8) overlap = 1;
            if (done8) got = 1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        checks++;
        if (!got || cyc != 8) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles (done seen %0d) expected 8", name, cyc, got);
        end
        checks++;
        if (busy_cnt != 8 || overlap) begin
            errors++;
            $display("FAIL %s busy: got %0d cycles overlap %0d expected 8 overlap 0",
                     name, busy_cnt, overlap);
        end
        checks++;
        if ({bout8, diff8} !== exp) begin
            errors++;
            $display("FAIL %s result: got bout=%b diff=%h expected bout=%b diff=%h",
                     name, bout8, diff8, exp[8], exp[7:0]);
        end
        @(posedge clk); #1;
        checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL %s done pulse width: got done=%b busy=%b expected 0 0", name, done8, busy8);
        end
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bi);
        logic [4:0] exp;
        int cyc;
        bit got;
        exp = model4(a, b, bi);
        @(negedge clk);
        a4 = a; b4 = b; bin4 = bi; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        cyc = 0; got = 0;
        while (!got && cyc < 12) begin
            if (done4) got = 1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        checks++;
        if (!got || cyc != 4 || {bout4, diff4} !== exp) begin
            errors++;
            $display("FAIL w4 a=%h b=%h bin=%b: got bout=%b diff=%h cyc=%0d expected bout=%b diff=%h cyc=4",
                     a, b, bi, bout4, diff4, cyc, exp[4], exp[3:0]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy8, done8, bout8, diff8} !== 11'b0) begin
            errors++;
            $display("FAIL reset w8: got busy=%b done=%b bout=%b diff=%h expected all 0",
                     busy8, done8, bout8, diff8);
        end
        checks++;
        if ({busy4, done4, bout4, diff4} !== 7'b0) begin
            errors++;
            $display("FAIL reset w4: got busy=%b done=%b bout=%b diff=%h expected all 0",
                     busy4, done4, bout4, diff4);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        run8(8'h05, 8'h03, 1'b0, "d_05_03");
        run8(8'h03, 8'h05, 1'b0, "d_03_05");
        run8(8'h00, 8'hFF, 1'b1, "d_00_ff_b");
        run8(8'hFF, 8'hFF, 1'b0, "d_ff_ff");
        run8(8'h03, 8'h05, 1'b0, "d_hold");
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (diff8 !== 8'hFE || bout8 !== 1'b1) begin
            errors++;
            $display("FAIL idle hold: got bout=%b diff=%h expected bout=1 diff=fe", bout8, diff8);
        end
    endtask

    task automatic test_ignore_start();
        int dones;
        int done_at;
        logic [7:0] d_cap;
        logic b_cap;
        dones = 0; done_at = -1; d_cap = '0; b_cap = 1'b0;
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk); #1;
            if (done8) begin
                dones++;
                done_at = i;
                d_cap = diff8;
                b_cap = bout8;
            end
            if (i == 3) begin
                a8 = 8'hAA; b8 = 8'h00; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
        end
        checks++;
        if (dones != 1 || done_at != 8) begin
            errors++;
            $display("FAIL ignore_start pulses: got %0d at %0d expected 1 at 8", dones, done_at);
        end
        checks++;
        if (d_cap !== 8'h0F || b_cap !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start result: got bout=%b diff=%h expected bout=0 diff=0f",
                     b_cap, d_cap);
        end
    endtask

    task automatic test_back_to_back();
        int first_at;
        int second_at;
        logic [8:0] r1;
        logic [8:0] r2;
        first_at = -1; second_at = -1; r1 = '0; r2 = '0;
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 24; i++) begin
            @(posedge clk); #1;
            if (done8) begin
                if (first_at < 0) begin
                    first_at = i;
                    r1 = {bout8, diff8};
                    a8 = 8'h01; b8 = 8'h02;
                end else if (second_at < 0) begin
                    second_at = i;
                    r2 = {bout8, diff8};
                    start8 = 1'b0;
                end else begin
                    second_at = -2;
                end
            end
        end
        start8 = 1'b0;
        checks++;
        if (r1 !== 9'h07F) begin
            errors++;
            $display("FAIL b2b first: got %h expected 07f", r1);
        end
        checks++;
        if (r2 !== 9'h1FF) begin
            errors++;
            $display("FAIL b2b second: got %h expected 1ff", r2);
        end
        checks++;
        if (first_at != 8 || second_at != 17) begin
            errors++;
            $display("FAIL b2b timing: got done at %0d and %0d expected 8 and 17", first_at, second_at);
        end
    endtask

    task automatic test_reset_mid_run();
        int dones;
        dones = 0;
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h22; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if ({busy8, done8, bout8, diff8} !== 11'b0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b done=%b bout=%b diff=%h expected all 0",
                     busy8, done8, bout8, diff8);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8 || busy8) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL mid_reset activity: got %0d busy/done cycles expected 0", dones);
        end
        run8(8'h55, 8'h22, 1'b1, "after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom), "random");
        end
    endtask

    task automatic test_exhaustive_w4();
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    run4(4'(a), 4'(b), 1'(bi));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        test_exhaustive_w4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
